// File: rtl/fb_write_arbiter_if.sv
// Signal bundle for the framebuffer write arbiter: the Avalon host port, the fill-engine
// controls, the vsync input and the RAM write port.
interface fb_write_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              host_chipselect;
  logic              host_write;
  logic [ADDR_W-1:0] host_address;
  logic [DATA_W-1:0] host_writedata;
  logic              host_waitrequest;

  logic              fill_start;
  logic              fill_on_vsync;
  logic              fill_abort;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [DATA_W-1:0] fill_pattern;
  logic              vga_vs;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] fill_remaining;

  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddress;
  logic [DATA_W-1:0] ram_data;

  modport slave (
    input  host_chipselect, host_write, host_address, host_writedata,
    output host_waitrequest,
    input  fill_start, fill_on_vsync, fill_abort, fill_base, fill_len, fill_pattern, vga_vs,
    output fill_busy, fill_done, fill_remaining,
    output ram_wren, ram_wraddress, ram_data
  );

  modport master (
    output host_chipselect, host_write, host_address, host_writedata,
    input  host_waitrequest,
    output fill_start, fill_on_vsync, fill_abort, fill_base, fill_len, fill_pattern, vga_vs,
    input  fill_busy, fill_done, fill_remaining,
    input  ram_wren, ram_wraddress, ram_data
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Single write port of the 1-bpp framebuffer, shared round-robin between Avalon host
// writes and a fill engine that writes a pattern over a wrapping word range.
module fb_write_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int FB_WORDS = 9600
) (
  input  logic            clk,
  input  logic            reset_n,
  fb_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, FILL, DONE} state_e;
  typedef enum logic {GNT_HOST, GNT_FILL} grant_e;

  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_WORDS - 1);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              vs_prev_q;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              host_req, fill_req, grant_host, grant_fill;
  logic [ADDR_W-1:0] base_clamp, len_clamp;

  assign host_req   = bus.host_chipselect & bus.host_write;
  assign fill_req   = (state_q == FILL);
  // On contention the requester that did not win last time is served.
  assign grant_host = host_req & (~fill_req | (last_grant_q == GNT_FILL));
  assign grant_fill = fill_req & ~grant_host;

  assign base_clamp = (bus.fill_base >= WORDS_A) ? '0 : bus.fill_base;
  assign len_clamp  = (bus.fill_len > WORDS_A) ? WORDS_A : bus.fill_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_FILL;
      vs_prev_q    <= 1'b1;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      pattern_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wren_q       <= 1'b0;
      wraddr_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      vs_prev_q    <= bus.vga_vs;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      pattern_q    <= pattern_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wren_q       <= wren_d;
      wraddr_q     <= wraddr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    pattern_d   = pattern_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fill_start) begin
          pattern_d   = bus.fill_pattern;
          cur_addr_d  = base_clamp;
          remaining_d = len_clamp;
          if (len_clamp == '0)        state_d = DONE;
          else if (bus.fill_on_vsync) state_d = WAIT_VS;
          else                        state_d = FILL;
        end
      end
      WAIT_VS: begin
        if (bus.fill_abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (vs_prev_q && !bus.vga_vs) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (grant_fill) begin
          cur_addr_d  = (cur_addr_q == LAST_A) ? '0 : cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) state_d = DONE;
        end
        // Abort wins over completion; the write granted this cycle still goes out.
        if (bus.fill_abort) begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (state_d == WAIT_VS) || (state_d == FILL);
    done_d       = (state_d == DONE);
    wren_d       = grant_host | grant_fill;
    wraddr_d     = wraddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (grant_host) begin
      wraddr_d     = bus.host_address;
      wdata_d      = bus.host_writedata;
      last_grant_d = GNT_HOST;
    end else if (grant_fill) begin
      wraddr_d     = cur_addr_q;
      wdata_d      = pattern_q;
      last_grant_d = GNT_FILL;
    end
  end

  assign bus.host_waitrequest = host_req & ~grant_host;
  assign bus.fill_busy        = busy_q;
  assign bus.fill_done        = done_q;
  assign bus.fill_remaining   = remaining_q;
  assign bus.ram_wren         = wren_q;
  assign bus.ram_wraddress    = wraddr_q;
  assign bus.ram_data         = wdata_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: expected RAM writes are queued when stimulus is driven
// and checked by a monitor as they appear on the write port.
module tb_fb_write_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int FB_WORDS = 9600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    int          base;
    int          len;
    logic [31:0] pat;
    int          first;
    int          count;
  } vec_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_count = 0;
  int  first_wr_cyc = -1;
  int  done_cnt = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      if (bus.fill_done) done_cnt++;
      if (bus.ram_wren) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h (no write expected)",
                   bus.ram_wraddress, bus.ram_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.ram_wraddress !== e.addr || bus.ram_data !== e.data) begin
            errors++;
            $display("FAIL ram_write got addr=%0d data=%h expected addr=%0d data=%h",
                     bus.ram_wraddress, bus.ram_data, e.addr, e.data);
          end
        end
        wr_count++;
        if (wr_count == 1) first_wr_cyc = cyc;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.host_chipselect = 1'b0;
    bus.host_write      = 1'b0;
    bus.host_address    = '0;
    bus.host_writedata  = '0;
    bus.fill_start      = 1'b0;
    bus.fill_on_vsync   = 1'b0;
    bus.fill_abort      = 1'b0;
    bus.fill_base       = '0;
    bus.fill_len        = '0;
    bus.fill_pattern    = '0;
    bus.vga_vs          = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    wr_count = 0;
    done_cnt = 0;
  endtask

  task automatic push_fill(input int first, input int count, input logic [31:0] pat);
    int a;
    a = first;
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({ADDR_W'(a), pat});
      a = (a == FB_WORDS - 1) ? 0 : a + 1;
    end
  endtask

  task automatic start_fill(input int base, input int len, input logic [31:0] pat,
                            input logic on_vs, output int s);
    bus.fill_base     = ADDR_W'(base);
    bus.fill_len      = ADDR_W'(len);
    bus.fill_pattern  = pat;
    bus.fill_on_vsync = on_vs;
    bus.fill_start    = 1'b1;
    s = cyc;
    step();
    bus.fill_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int s, output int done_at, output logic busy1);
    done_at = -1;
    busy1   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cyc == s + 1) busy1 = bus.fill_busy;
      if (bus.fill_done) begin
        done_at = cyc;
        break;
      end
    end
    if (done_at < 0) begin
      checks++;
      errors++;
      $display("FAIL fill_done_timeout got=none expected=pulse within %0d cycles", budget);
    end
  endtask

  vec_t vecs[5];

  initial begin
    int   s, done_at, e;
    logic busy1;

    vecs[0] = '{base: 9598,  len: 4,     pat: 32'hFFFF_FFFF, first: 9598, count: 4};
    vecs[1] = '{base: 10000, len: 3,     pat: 32'hA5A5_A5A5, first: 0,    count: 3};
    vecs[2] = '{base: 0,     len: 0,     pat: 32'h1234_5678, first: 0,    count: 0};
    vecs[3] = '{base: 100,   len: 20000, pat: 32'h0000_0000, first: 100,  count: 9600};
    vecs[4] = '{base: 9599,  len: 1,     pat: 32'h0F0F_0F0F, first: 9599, count: 1};

    // Reset state
    idle_inputs();
    @(posedge clk);
    #1;
    check("reset_wren", bus.ram_wren, 0);
    check("reset_wraddress", bus.ram_wraddress, 0);
    check("reset_busy", bus.fill_busy, 0);
    do_reset();

    // Plain host writes, including one beyond the framebuffer
    bus.host_chipselect = 1'b1;
    bus.host_write      = 1'b1;
    bus.host_address    = 15'h0010;
    bus.host_writedata  = 32'hDEAD_BEEF;
    #1;
    check("host_wait_idle", bus.host_waitrequest, 0);
    exp_q.push_back({15'h0010, 32'hDEAD_BEEF});
    step();
    bus.host_address   = 15'h4000;
    bus.host_writedata = 32'h0BAD_F00D;
    exp_q.push_back({15'h4000, 32'h0BAD_F00D});
    step();
    idle_inputs();
    repeat (2) step();
    check("host_writes_seen", wr_count, 2);

    // Reset asserted mid-fill clears outputs at once
    wr_count = 0;
    push_fill(0, 100, 32'h5555_AAAA);
    start_fill(0, 100, 32'h5555_AAAA, 1'b0, s);
    repeat (4) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_wren", bus.ram_wren, 0);
    check("midreset_wraddress", bus.ram_wraddress, 0);
    check("midreset_data", bus.ram_data, 0);
    check("midreset_busy", bus.fill_busy, 0);
    check("midreset_remaining", bus.fill_remaining, 0);
    do_reset();

    // Table of immediate fills with no host traffic
    for (int v = 0; v < 5; v++) begin
      wr_count = 0;
      done_cnt = 0;
      push_fill(vecs[v].first, vecs[v].count, vecs[v].pat);
      start_fill(vecs[v].base, vecs[v].len, vecs[v].pat, 1'b0, s);
      wait_done(FB_WORDS + 20, s, done_at, busy1);
      repeat (2) step();
      check("vec_done_latency", done_at - s, vecs[v].count + 1);
      check("vec_busy_after_start", busy1, (vecs[v].count > 0) ? 1 : 0);
      check("vec_write_count", wr_count, vecs[v].count);
      check("vec_done_pulses", done_cnt, 1);
      check("vec_remaining_end", bus.fill_remaining, 0);
      check("vec_queue_drained", exp_q.size(), 0);
    end

    // Contention: host held on 0x0100 from the first fill cycle
    do_reset();
    start_fill(0, 8, 32'hC3C3_C3C3, 1'b0, s);
    bus.host_chipselect = 1'b1;
    bus.host_write      = 1'b1;
    bus.host_address    = 15'h0100;
    bus.host_writedata  = 32'h7777_1111;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({15'h0100, 32'h7777_1111});
      exp_q.push_back({ADDR_W'(k), 32'hC3C3_C3C3});
    end
    for (int i = 0; i < 16; i++) begin
      #1;
      check("contend_waitrequest", bus.host_waitrequest, (i % 2 == 1) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    #1;
    check("contend_done_at_16", bus.fill_done, 1);
    repeat (3) step();
    check("contend_write_count", wr_count, 16);

    // Vsync deferral: already-low vsync must not trigger
    do_reset();
    bus.vga_vs = 1'b0;
    repeat (2) step();
    push_fill(50, 3, 32'h3C3C_3C3C);
    start_fill(50, 3, 32'h3C3C_3C3C, 1'b1, s);
    repeat (5) step();
    check("vs_no_early_write", wr_count, 0);
    check("vs_busy_waiting", bus.fill_busy, 1);
    bus.vga_vs = 1'b1;
    repeat (2) step();
    bus.vga_vs = 1'b0;
    e = cyc;
    wait_done(50, e, done_at, busy1);
    repeat (2) step();
    check("vs_first_write_delay", first_wr_cyc - e, 2);
    check("vs_write_count", wr_count, 3);

    // Abort after 10 writes
    do_reset();
    push_fill(0, 100, 32'h9999_6666);
    start_fill(0, 100, 32'h9999_6666, 1'b0, s);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (wr_count >= 10) break;
    end
    check("abort_reached_10", wr_count, 10);
    bus.fill_abort = 1'b1;
    step();
    bus.fill_abort = 1'b0;
    check("abort_busy_clear", bus.fill_busy, 0);
    check("abort_remaining_zero", bus.fill_remaining, 0);
    repeat (4) step();
    check("abort_total_writes", wr_count, 11);
    check("abort_no_done", done_cnt, 0);
    exp_q.delete();

    // Start together with abort in IDLE still starts the fill
    wr_count = 0;
    push_fill(7, 2, 32'h1357_9BDF);
    bus.fill_abort = 1'b1;
    start_fill(7, 2, 32'h1357_9BDF, 1'b0, s);
    bus.fill_abort = 1'b0;
    wait_done(20, s, done_at, busy1);
    repeat (2) step();
    check("restart_write_count", wr_count, 2);
    check("restart_done_latency", done_at - s, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
